// File: rtl/cpe_pkg.sv
// Shared encodings and defaults for the CPE data-memory controller and its SRAM model.
package cpe_pkg;

  localparam int ADDR_W_DEF = 15;

  localparam logic [1:0] SEL_BYTE    = 2'b00;
  localparam logic [1:0] SEL_HALF    = 2'b01;
  localparam logic [1:0] SEL_WORD    = 2'b10;
  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // Index of the final beat: 0/1/3 for byte/half/word.
  function automatic logic [1:0] beats_m1(input logic [1:0] sel);
    case (sel)
      SEL_HALF: return 2'd1;
      SEL_WORD: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cpe_dmem_ctrl_if.sv
// CPU-side load/store bus of the data-memory controller.
interface cpe_dmem_ctrl_if;
  logic        mem_rd_w_i_h;
  logic        mem_wr_w_i_h;
  logic [31:0] mem_addr_w_i;
  logic [31:0] mem_data_w_i;
  logic [1:0]  mem_byte_sel_w_i;
  logic [31:0] mem_data_w_o;
  logic        mem_busy_w_o_h;
  logic        mem_done_w_o_h;
  logic        mem_err_w_o_h;

  modport master (
    output mem_rd_w_i_h, mem_wr_w_i_h, mem_addr_w_i, mem_data_w_i, mem_byte_sel_w_i,
    input  mem_data_w_o, mem_busy_w_o_h, mem_done_w_o_h, mem_err_w_o_h
  );

  modport slave (
    input  mem_rd_w_i_h, mem_wr_w_i_h, mem_addr_w_i, mem_data_w_i, mem_byte_sel_w_i,
    output mem_data_w_o, mem_busy_w_o_h, mem_done_w_o_h, mem_err_w_o_h
  );
endinterface

// File: rtl/cpe_dmem_sram.sv
// Behavioural byte-wide SRAM with one-cycle registered read data.
module cpe_dmem_sram #(
  parameter int ADDR_W = cpe_pkg::ADDR_W_DEF
) (
  input  logic              clk_w_i,
  input  logic              en_w_i_h,
  input  logic              we_w_i_h,
  input  logic [ADDR_W-1:0] addr_w_i,
  input  logic [7:0]        data_w_i,
  output logic [7:0]        data_w_o
);

  logic [7:0] mem [2**ADDR_W];

  // NOTE: storage arrays carry no reset; clearing them would need a write per entry.
  always_ff @(posedge clk_w_i) begin
    if (en_w_i_h) begin
      if (we_w_i_h) mem[addr_w_i] <= data_w_i;
      else          data_w_o      <= mem[addr_w_i];
    end
  end

endmodule

// File: rtl/cpe_dmem_ctrl.sv
// Serialises 8/16/32-bit big-endian CPU loads and stores onto a byte-wide SRAM.
module cpe_dmem_ctrl
  import cpe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk_w_i,
  input  logic                 res_w_i_l,
  cpe_dmem_ctrl_if.slave       cpu,
  output logic [ADDR_W-1:0]    sram_addr_w_o,
  output logic [7:0]           sram_data_w_o,
  input  logic [7:0]           sram_data_w_i,
  output logic                 sram_en_w_o_h,
  output logic                 sram_we_w_o_h
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          beat_q, last_q;
  logic [31:0]         wsh_q, wsh_init;
  logic [23:0]         acc_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                req, req_err;
  logic                busy, done;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^cpu.mem_addr_w_i[31:ADDR_W];

  assign req     = cpu.mem_rd_w_i_h | cpu.mem_wr_w_i_h;
  assign req_err = (cpu.mem_byte_sel_w_i == SEL_ILLEGAL)
                 | (cpu.mem_rd_w_i_h & cpu.mem_wr_w_i_h)
                 | ((cpu.mem_byte_sel_w_i == SEL_HALF) & cpu.mem_addr_w_i[0])
                 | ((cpu.mem_byte_sel_w_i == SEL_WORD) & (|cpu.mem_addr_w_i[1:0]));

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wsh_init = cpu.mem_data_w_i;
    case (cpu.mem_byte_sel_w_i)
      SEL_BYTE: wsh_init = cpu.mem_data_w_i << 24;
      SEL_HALF: wsh_init = cpu.mem_data_w_i << 16;
      default:  wsh_init = cpu.mem_data_w_i;
    endcase
    case (state_q)
      IDLE, DONE: begin
        if (!req)         state_d = IDLE;
        else if (req_err) state_d = DONE;
        else              state_d = cpu.mem_wr_w_i_h ? WRITE : READ;
      end
      WRITE:   if (beat_q == last_q) state_d = DONE;
      READ:    if (beat_q == last_q) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      wsh_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (req) begin
            addr_q <= cpu.mem_addr_w_i[ADDR_W-1:0];
            beat_q <= '0;
            last_q <= beats_m1(cpu.mem_byte_sel_w_i);
            wsh_q  <= wsh_init;
            acc_q  <= '0;
            err_q  <= req_err;
            if (req_err && cpu.mem_rd_w_i_h) rdata_q <= '0;
          end
        end
        WRITE: begin
          beat_q <= beat_q + 2'd1;
          addr_q <= addr_q + 1'b1;
          wsh_q  <= wsh_q << 8;
        end
        READ: begin
          beat_q <= beat_q + 2'd1;
          addr_q <= addr_q + 1'b1;
          // Read data lags its address by one cycle, so beat 0 has nothing to capture yet.
          if (beat_q != 2'd0) acc_q <= {acc_q[15:0], sram_data_w_i};
        end
        DRAIN:   rdata_q <= {acc_q, sram_data_w_i};
        default: ;
      endcase
    end
  end

  assign busy = (state_q == WRITE) | (state_q == READ) | (state_q == DRAIN);
  assign done = (state_q == DONE);

  assign cpu.mem_busy_w_o_h = busy;
  assign cpu.mem_done_w_o_h = done;
  assign cpu.mem_err_w_o_h  = done & err_q;
  assign cpu.mem_data_w_o   = rdata_q;

  assign sram_en_w_o_h = (state_q == WRITE) | (state_q == READ);
  assign sram_we_w_o_h = (state_q == WRITE);
  assign sram_addr_w_o = sram_en_w_o_h ? addr_q : '0;
  assign sram_data_w_o = sram_we_w_o_h ? wsh_q[31:24] : 8'h00;

endmodule

// File: tb/tb_cpe_dmem_ctrl.sv
// Directed and randomized checks of cpe_dmem_ctrl against a byte-array memory model.
module tb_cpe_dmem_ctrl;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_wdata, sram_rdata;
  logic          sram_en, sram_we;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  ref_mem [0:(2**AW)-1];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  cpe_dmem_ctrl_if bus ();

  cpe_dmem_ctrl #(.ADDR_W(AW)) u_dut (
    .clk_w_i       (clk),
    .res_w_i_l     (rst_n),
    .cpu           (bus),
    .sram_addr_w_o (sram_addr),
    .sram_data_w_o (sram_wdata),
    .sram_data_w_i (sram_rdata),
    .sram_en_w_o_h (sram_en),
    .sram_we_w_o_h (sram_we)
  );

  cpe_dmem_sram #(.ADDR_W(AW)) u_sram (
    .clk_w_i  (clk),
    .en_w_i_h (sram_en),
    .we_w_i_h (sram_we),
    .addr_w_i (sram_addr),
    .data_w_i (sram_wdata),
    .data_w_o (sram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] obs_vec();
    return {4'b0, bus.mem_busy_w_o_h, bus.mem_done_w_o_h, bus.mem_err_w_o_h,
            sram_en, sram_we, sram_addr, sram_wdata};
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sel);
    bus.mem_rd_w_i_h     = rd;
    bus.mem_wr_w_i_h     = wr;
    bus.mem_addr_w_i     = a;
    bus.mem_data_w_i     = d;
    bus.mem_byte_sel_w_i = sel;
  endtask

  task automatic clear_req();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
  endtask

  // Called just after the accepting edge; walks cycles 1..done against the model.
  task automatic expect_op(input string tag, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    int          n, done_c;
    bit          e, en, we;
    logic [AW-1:0] base, ad;
    logic [7:0]  bt;
    logic [31:0] tmp, ld, exp_v;
    n = (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
    e = (sel == 2'b11) || (rd && wr) || (sel == 2'b01 && a[0]) || (sel == 2'b10 && a[1:0] != 2'b00);
    done_c = e ? 1 : (wr ? n + 1 : n + 2);
    base = a[AW-1:0];
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      en  = !e && (c <= n);
      we  = en && wr;
      ad  = en ? base + AW'(c - 1) : '0;
      tmp = d >> (8 * (n - c));
      bt  = we ? tmp[7:0] : 8'h00;
      if (we) ref_mem[ad] = bt;
      if (c == done_c) begin
        if (e) begin
          if (rd) exp_rdata = 32'h0;
        end else if (rd) begin
          ld = 32'h0;
          for (int k = 0; k < n; k++) ld = (ld << 8) | 32'(ref_mem[base + AW'(k)]);
          exp_rdata = ld;
        end
      end
      exp_v = {4'b0, 1'(c < done_c), 1'(c == done_c), 1'(c == done_c && e), en, we, ad, bt};
      check($sformatf("%s_cyc%0d", tag, c), obs_vec(), exp_v);
      check($sformatf("%s_rdata%0d", tag, c), bus.mem_data_w_o, exp_rdata);
    end
  endtask

  task automatic op(input string tag, input logic rd, input logic wr,
                    input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    @(negedge clk);
    check({tag, "_idle"}, obs_vec(), 32'h0);
    drive(rd, wr, a, d, sel);
    @(posedge clk);
    #1 clear_req();
    expect_op(tag, rd, wr, a, d, sel);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rd, wr;
    logic [1:0]  sel;
    logic [31:0] a;
    int          r;

    clear_req();
    exp_rdata = 32'h0;
    rst_n = 1'b0;
    #1;
    check("reset_outs", obs_vec(), 32'h0);
    check("reset_rdata", bus.mem_data_w_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op("sw_beef", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10);
    check("sram10", 32'(u_sram.mem[16'h10]), 32'hDE);
    check("sram13", 32'(u_sram.mem[16'h13]), 32'hEF);
    op("lw_beef", 1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    check("lw_beef_val", bus.mem_data_w_o, 32'hDEADBEEF);
    op("sb_5a", 1'b0, 1'b1, 32'h13, 32'h0000005A, 2'b00);
    op("lw_5a", 1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    check("lw_5a_val", bus.mem_data_w_o, 32'hDEADBE5A);
    op("lh_12", 1'b1, 1'b0, 32'h12, 32'h0, 2'b01);
    check("lh_12_val", bus.mem_data_w_o, 32'h0000BE5A);

    op("lh_mis", 1'b1, 1'b0, 32'h11, 32'h0, 2'b01);
    op("sel_ill", 1'b1, 1'b0, 32'h10, 32'h0, 2'b11);
    op("rdwr", 1'b1, 1'b1, 32'h20, 32'h12345678, 2'b10);
    op("sw_mis", 1'b0, 1'b1, 32'h22, 32'h12345678, 2'b10);

    // Second request held through a busy store is taken only in DONE.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30, 32'hA5A50F0F, 2'b10);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 32'h30, 32'h0, 2'b10);
    expect_op("b2b_sw", 1'b0, 1'b1, 32'h30, 32'hA5A50F0F, 2'b10);
    @(posedge clk);
    #1 clear_req();
    expect_op("b2b_lw", 1'b1, 1'b0, 32'h30, 32'h0, 2'b10);
    check("b2b_val", bus.mem_data_w_o, 32'hA5A50F0F);

    // Reset in the third beat of a word store.
    op("sw_pre", 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'b10);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h40, 32'h11223344, 2'b10);
    @(posedge clk);
    #1 clear_req();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outs", obs_vec(), 32'h0);
    check("rst_mid_rdata", bus.mem_data_w_o, 32'h0);
    exp_rdata = 32'h0;
    ref_mem[15'h40] = 8'h11;
    ref_mem[15'h41] = 8'h22;
    @(negedge clk);
    check("rst_sram40", 32'(u_sram.mem[16'h40]), 32'h11);
    check("rst_sram41", 32'(u_sram.mem[16'h41]), 32'h22);
    check("rst_sram43", 32'(u_sram.mem[16'h43]), 32'h0D);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
    @(posedge clk);
    #1 clear_req();
    expect_op("lw_after_rst", 1'b1, 1'b0, 32'h40, 32'h0, 2'b10);

    // Address wrap and aliasing of the upper address bits.
    op("sw_zero", 1'b0, 1'b1, 32'h0, 32'h01020304, 2'b10);
    op("sb_top", 1'b0, 1'b1, 32'h7FFF, 32'h000000AA, 2'b00);
    check("sram7fff", 32'(u_sram.mem[16'h7FFF]), 32'hAA);
    op("lw_alias", 1'b1, 1'b0, 32'hFFFF_8000, 32'h0, 2'b10);
    check("lw_alias_val", bus.mem_data_w_o, 32'h01020304);
    op("lb_top", 1'b1, 1'b0, 32'h7FFF, 32'h0, 2'b00);
    check("lb_top_val", bus.mem_data_w_o, 32'h000000AA);

    for (int i = 0; i < 4; i++)
      op("fill", 1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 2'b10);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 1) || (r >= 5);
      wr = (r < 5);
      r  = $urandom_range(0, 7);
      sel = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      a  = ($urandom & 32'hFFFF_8000) | (32'h100 + 32'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) != 0) begin
        if (sel == 2'b01) a[0] = 1'b0;
        if (sel == 2'b10) a[1:0] = 2'b00;
      end
      op($sformatf("rnd%0d", i), rd, wr, a, $urandom, sel);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
